// File: rtl/pixel_window_sequencer_if.sv
// Video-in / window-out signal bundle between the pixel source, the
// window sequencer and the line-buffer datapath.
interface pixel_window_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              h_sync_i;
    logic              v_sync_i;
    logic              pixel_valid_i;
    logic [ADDR_W-1:0] lb_addr;
    logic              lb_we;
    logic              win_valid;
    logic [ADDR_W-1:0] win_col;
    logic [ADDR_W-1:0] win_row;
    logic              h_sync_o;
    logic              v_sync_o;
    logic              frame_done;
    logic              err_overflow;

    modport master (
        output h_sync_i, v_sync_i, pixel_valid_i,
        input  lb_addr, lb_we, win_valid, win_col, win_row,
               h_sync_o, v_sync_o, frame_done, err_overflow
    );

    modport slave (
        input  h_sync_i, v_sync_i, pixel_valid_i,
        output lb_addr, lb_we, win_valid, win_col, win_row,
               h_sync_o, v_sync_o, frame_done, err_overflow
    );
endinterface

// File: rtl/pixel_window_sequencer.sv
// Pixel-window sequencer: tracks column/row of the incoming video stream,
// drives line-buffer address/enable and flags when a full 5x5 window of
// real pixels is present, with sync outputs re-aligned to window timing.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; pixels ignored until the first v_sync rising edge
// FILL  | fewer than 4 completed lines in this frame, no window yet
// RUN   | at least 4 completed lines, windows emitted once col >= 4
module pixel_window_sequencer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    pixel_window_sequencer_if.slave  vid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] W_LIM = ADDR_W'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0] H_LIM = ADDR_W'(IMG_HEIGHT);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] THREE = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] col, col_nxt;
    logic [ADDR_W-1:0] row, row_nxt;
    logic              h_prev, v_prev;
    logic              h_rise, v_rise;
    logic              pix_cand, accept, col_ovf;
    logic              row_inc, row_ovf;
    logic              win_hit;
    logic              frame_err;

    // Sync edges and pixel qualification; a pixel sharing a cycle with
    // either sync level is never written.
    always_comb begin
        h_rise   = vid.h_sync_i & ~h_prev;
        v_rise   = vid.v_sync_i & ~v_prev;
        pix_cand = vid.pixel_valid_i & ~vid.h_sync_i & ~vid.v_sync_i & (state != IDLE);
        accept   = pix_cand & (col < W_LIM);
        col_ovf  = pix_cand & (col == W_LIM);
        row_inc  = h_rise & ~v_rise & (col != '0) & (state != IDLE);
        row_ovf  = row_inc & (row == H_LIM);
        win_hit  = accept & (state == RUN) & (col >= FOUR);
    end

    // State and position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            h_prev <= 1'b0;
            v_prev <= 1'b0;
        end else begin
            state  <= state_nxt;
            col    <= col_nxt;
            row    <= row_nxt;
            h_prev <= vid.h_sync_i;
            v_prev <= vid.v_sync_i;
        end
    end

    // Next state and counter updates; v_sync wins over h_sync, row saturates.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        if (v_rise) begin
            state_nxt = FILL;
            col_nxt   = '0;
            row_nxt   = '0;
        end else if (state != IDLE) begin
            if (h_rise) begin
                col_nxt = '0;
                if (row_inc && !row_ovf) begin
                    row_nxt = row + ONE;
                end
            end else if (accept) begin
                col_nxt = col + ONE;
            end
            if (state == FILL && row_inc && row == THREE) begin
                state_nxt = RUN;
            end
        end
    end

    // Window outputs, delayed syncs, frame completion and overflow flags,
    // all one cycle behind the pixel to match the shift-register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.win_valid    <= 1'b0;
            vid.win_col      <= '0;
            vid.win_row      <= '0;
            vid.h_sync_o     <= 1'b0;
            vid.v_sync_o     <= 1'b0;
            vid.frame_done   <= 1'b0;
            vid.err_overflow <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            vid.win_valid <= win_hit;
            if (win_hit) begin
                vid.win_col <= (col >= TWO) ? col - TWO : '0;
                vid.win_row <= (row >= TWO) ? row - TWO : '0;
            end
            vid.h_sync_o     <= vid.h_sync_i;
            vid.v_sync_o     <= vid.v_sync_i;
            vid.frame_done   <= v_rise & (state != IDLE) & (row == H_LIM) & ~frame_err;
            vid.err_overflow <= vid.err_overflow | col_ovf | row_ovf;
            // Per-frame copy of the overflow so a stale sticky flag from an
            // earlier frame does not suppress frame_done forever.
            frame_err        <= v_rise ? 1'b0 : (frame_err | col_ovf | row_ovf);
        end
    end

    assign vid.lb_addr = col;
    assign vid.lb_we   = accept;

endmodule
